rxll_frame_ctrl: RTL
====================

// Module: rxll_frame_ctrl
// PURPOSE
//  Read-side sequencer for the 36-bit FWFT receive LocalLink FIFO. Waits until a complete frame
//  is buffered (eof_rdy), then streams it word by word to the FIS consumer over a valid/ready
//  interface. Captures the FIS type from the SOF word and counts words. Truncates oversize frames
//  and drops orphan words. Reports one done pulse per frame with its length and error status.
// PARAMETERS
//  C_MAX_WORDS  2049  max dwords forwarded per frame (data FIS: 1 header + 2048 payload)
//  C_LEN_W      12    width of word counter / done_len; must hold C_MAX_WORDS
// PORTS
//  clk           in   1        FIFO read clock; sole clock of this block
//  rst           in   1        synchronous, active-high reset
//  enable        in   1        allow a new frame to start; sampled only in IDLE
//  fifo_rd_do    in   36       FIFO head word: [31:0] data, [32] SOF, [33] CRC/err, [34] EOF, [35] rsvd
//  fifo_rd_empty in   1        FIFO empty
//  fifo_eof_rdy  in   1        at least one complete frame (EOF written) is in the FIFO
//  fifo_rd_en    out  1        pop the head word
//  out_data      out  32       = fifo_rd_do[31:0]
//  out_valid     out  1        out_data valid
//  out_sof       out  1        first word of forwarded frame
//  out_eof       out  1        last forwarded word (real EOF or truncation point)
//  out_ready     in   1        consumer accepts word when out_valid && out_ready
//  fis_type      out  8        fifo_rd_do[7:0] of the last SOF word popped; held until the next SOF
//  busy          out  1        state != IDLE
//  done          out  1        one-cycle pulse per completed frame
//  done_len      out  C_LEN_W  dwords popped for the frame, capped at C_MAX_WORDS; valid with done
//  done_err      out  1        OR of bit33 over the frame, or a stray SOF after word 0; valid with done
//  done_ovf      out  1        frame exceeded C_MAX_WORDS and was truncated; valid with done
// BEHAVIOUR
//  States: IDLE, XFER, DROP, DONE. pop = fifo_rd_en. All registered outputs reset to 0.
//   The state resets to IDLE and the counter and flags clear. Reset mid-frame abandons the frame
//   without a done pulse.
//  IDLE: when enable && fifo_eof_rdy && !fifo_rd_empty:
//   SOF=1 -> XFER; no pop in this cycle.
//   SOF=0 -> DROP (orphan words); sets err.
//   Otherwise stays in IDLE.
//  XFER: out_valid = !fifo_rd_empty; fifo_rd_en = out_valid && out_ready (combinational).
//   out_sof = 1 on word 0. out_eof = bit34 || (cnt == C_MAX_WORDS-1).
//   Each pop increments cnt; word 0 loads fis_type; every pop ORs bit33 into err.
//   A SOF on a word other than word 0 is forwarded as data and sets err.
//   Pop with EOF -> DONE. This includes a 1-word frame with SOF and EOF set together.
//   Pop at cnt == C_MAX_WORDS-1 without EOF -> DROP and sets ovf.
//  DROP: out_valid = 0; fifo_rd_en = !fifo_rd_empty. Discards words until a pop with EOF -> DONE.
//   cnt does not advance past C_MAX_WORDS; bit33 still ORs into err.
//  DONE: done = 1 for one cycle with done_len/err/ovf, then -> IDLE.
//   This one-cycle gap lets fifo_eof_rdy settle after the EOF pop.
//  enable is ignored once a frame has started; the frame always runs to completion.
//  Throughput: 1 word/clk while out_ready=1 and the FIFO is non-empty. There are 2 idle cycles
//   between frames (IDLE and DONE).
//  Empty mid-frame (EOF already in FIFO, so only transient): stall with no pop; state is held.
// TESTING
//  4-word frame, SOF word 0x0000_0046, out_ready=1 -> 4 pops on consecutive clks; fis_type=0x46;
//   done with len=4, err=0, ovf=0.
//  Same frame with out_ready toggling 1,0,1,0 -> no pop while ready=0; data order kept; done_len=4.
//  1-word frame with SOF+EOF -> out_sof=out_eof=1 on the same word; done_len=1.
//  C_MAX_WORDS=4, 6-word frame -> 4 words forwarded with out_eof on word 3; 2 words dropped;
//   done_len=4, ovf=1.
//  Orphan 2 words (no SOF, EOF on 2nd) followed by a good frame -> orphans popped with out_valid=0;
//   done err=1 len=2; the next frame is forwarded normally.
//  Bit33 set on word 2 -> done_err=1. enable=0 with a frame buffered -> no pop, busy=0.
//   rst mid-XFER -> IDLE next clk, all outputs 0, no done pulse.

Source files
------------

// File: rtl/rxll_frame_ctrl.sv
// Read-side sequencer for the 36-bit FWFT receive LocalLink FIFO: forwards one buffered frame at a time,
// truncating oversize frames, discarding orphan words, and reporting length/error status per frame.
module rxll_frame_ctrl #(
  parameter int C_MAX_WORDS = 2049,
  parameter int C_LEN_W     = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [35:0]        fifo_rd_do,
  input  logic               fifo_rd_empty,
  input  logic               fifo_eof_rdy,
  output logic               fifo_rd_en,
  output logic [31:0]        out_data,
  output logic               out_valid,
  output logic               out_sof,
  output logic               out_eof,
  input  logic               out_ready,
  output logic [7:0]         fis_type,
  output logic               busy,
  output logic               done,
  output logic [C_LEN_W-1:0] done_len,
  output logic               done_err,
  output logic               done_ovf
);

  typedef enum logic [1:0] {IDLE, XFER, DROP, DONE} state_t;

  localparam logic [C_LEN_W-1:0] CNT_MAX  = C_LEN_W'(C_MAX_WORDS);
  localparam logic [C_LEN_W-1:0] CNT_LAST = C_LEN_W'(C_MAX_WORDS - 1);

  state_t             state;
  logic [C_LEN_W-1:0] cnt;
  logic               err;
  logic               ovf;

  logic               w_sof;
  logic               w_bad;
  logic               w_eof;
  logic               unused_rsvd;
  logic [C_LEN_W-1:0] cnt_inc;
  logic               frame_err;

  assign w_sof       = fifo_rd_do[32];
  assign w_bad       = fifo_rd_do[33];
  assign w_eof       = fifo_rd_do[34];
  assign unused_rsvd = fifo_rd_do[35];
  assign out_data    = fifo_rd_do[31:0];
  assign busy        = (state != IDLE);

  // Length saturates so dropped tail words of a truncated frame do not wrap the count.
  assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign frame_err = err | w_bad | ((state == XFER) && (cnt != '0) && w_sof);

  always_comb begin
    out_valid  = 1'b0;
    out_sof    = 1'b0;
    out_eof    = 1'b0;
    fifo_rd_en = 1'b0;
    case (state)
      XFER: begin
        out_valid  = !fifo_rd_empty;
        out_sof    = out_valid && (cnt == '0);
        out_eof    = out_valid && (w_eof || (cnt == CNT_LAST));
        fifo_rd_en = out_valid && out_ready;
      end
      DROP:    fifo_rd_en = !fifo_rd_empty;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      err      <= 1'b0;
      ovf      <= 1'b0;
      fis_type <= 8'h00;
      done     <= 1'b0;
      done_len <= '0;
      done_err <= 1'b0;
      done_ovf <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && fifo_eof_rdy && !fifo_rd_empty) begin
            cnt <= '0;
            ovf <= 1'b0;
            // A head word without SOF cannot belong to a forwardable frame.
            err   <= !w_sof;
            state <= w_sof ? XFER : DROP;
          end
        end
        XFER: begin
          if (fifo_rd_en) begin
            cnt <= cnt_inc;
            err <= frame_err;
            if (cnt == '0) fis_type <= fifo_rd_do[7:0];
            if (w_eof) begin
              state    <= DONE;
              done     <= 1'b1;
              done_len <= cnt_inc;
              done_err <= frame_err;
              done_ovf <= ovf;
            end else if (cnt == CNT_LAST) begin
              state <= DROP;
              ovf   <= 1'b1;
            end
          end
        end
        DROP: begin
          if (fifo_rd_en) begin
            cnt <= cnt_inc;
            err <= frame_err;
            if (w_eof) begin
              state    <= DONE;
              done     <= 1'b1;
              done_len <= cnt_inc;
              done_err <= frame_err;
              done_ovf <= ovf;
            end
          end
        end
        // One dead cycle so fifo_eof_rdy reflects the EOF just popped.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
